// File: rtl/muldiv_pkg.sv
// Shared types and sizing for the iterative RV32M multiply/divide unit.
// The divide datapath is present only when MULDIV_DIV_EN is defined.
package muldiv_pkg;

  localparam int MULDIV_XLEN  = 32;
  localparam int MULDIV_CNT_W = $clog2(MULDIV_XLEN);

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } muldiv_state_e;

  function automatic int cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/muldiv_divider.sv
// Restoring unsigned divide datapath: one shift-subtract step per cycle on
// operand magnitudes; next-step values are exposed so the caller can capture them.
module muldiv_divider
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = MULDIV_XLEN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  step,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic [DATA_WIDTH-1:0] quot_next,
  output logic [DATA_WIDTH-1:0] rem_next,
  output logic                  div_zero
);

  localparam int W = DATA_WIDTH;

  logic [W-1:0] quot_q;
  logic [W-1:0] rem_q;
  logic [W-1:0] divisor_q;
  logic [W:0]   shifted;
  logic [W:0]   diff;

  // Bit W of the difference is the borrow: set means the trial subtract failed.
  always_comb begin
    shifted = {rem_q, quot_q[W-1]};
    diff    = shifted - {1'b0, divisor_q};
    if (diff[W]) begin
      rem_next  = shifted[W-1:0];
      quot_next = {quot_q[W-2:0], 1'b0};
    end else begin
      rem_next  = diff[W-1:0];
      quot_next = {quot_q[W-2:0], 1'b1};
    end
  end

  assign div_zero = (divisor_q == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quot_q    <= '0;
      rem_q     <= '0;
      divisor_q <= '0;
    end else if (load) begin
      quot_q    <= dividend;
      rem_q     <= '0;
      divisor_q <= divisor;
    end else if (step) begin
      quot_q    <= quot_next;
      rem_q     <= rem_next;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit, fixed DATA_WIDTH-step latency.
// Define MULDIV_DIV_EN to build the divider; otherwise ops 4-7 report illegal_op.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH    = MULDIV_XLEN,
  parameter int ADDRESS_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [2:0]               op,
  input  logic [DATA_WIDTH-1:0]    rs1_val,
  input  logic [DATA_WIDTH-1:0]    rs2_val,
  input  logic [ADDRESS_WIDTH-1:0] rd_in,
  output logic                     busy,
  output logic                     done,
  output logic [DATA_WIDTH-1:0]    result,
  output logic [ADDRESS_WIDTH-1:0] rd_out,
  output logic                     wb_en,
  output logic                     illegal_op
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = cnt_w(W);

  muldiv_state_e           state_q, state_d;
  logic [CW-1:0]           count_q;
  muldiv_op_e              op_q;
  muldiv_op_e              op_in;
  logic                    neg_a_q, neg_b_q, illegal_q, illegal_d;
  logic [W-1:0]            mcand_q;
  logic [2*W-1:0]          prod_q, prod_next, prod_fix;
  logic [W:0]              mul_sum;
  logic [W-1:0]            result_q, result_d;
  logic [W-1:0]            quot_fix, rem_fix;
  logic [ADDRESS_WIDTH-1:0] rd_q;
  logic                    accept, last;
  logic                    sign_a, sign_b;
  logic [W-1:0]            mag_a, mag_b;

  assign op_in = muldiv_op_e'(op);

  // Operands are stored as magnitudes; signs are reapplied after the last step.
  always_comb begin
    sign_a = rs1_val[W-1] & (op_in inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
    sign_b = rs2_val[W-1] & (op_in inside {OP_MUL, OP_MULH, OP_DIV, OP_REM});
    mag_a  = sign_a ? -rs1_val : rs1_val;
    mag_b  = sign_b ? -rs2_val : rs2_val;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    last    = 1'b0;
    unique case (state_q)
      IDLE: if (start) begin
        state_d = CALC;
        accept  = 1'b1;
      end
      CALC: if (count_q == CW'(W - 1)) begin
        state_d = DONE;
        last    = 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Shift-add: the multiplier sits in the low half and is consumed LSB first.
  assign mul_sum   = {1'b0, prod_q[2*W-1:W]} + (prod_q[0] ? {1'b0, mcand_q} : {(W+1){1'b0}});
  assign prod_next = {mul_sum, prod_q[W-1:1]};
  assign prod_fix  = (neg_a_q ^ neg_b_q) ? -prod_next : prod_next;

`ifdef MULDIV_DIV_EN
  logic [W-1:0] quot_next, rem_next;
  logic         div_zero;

  muldiv_divider #(.DATA_WIDTH(W)) u_divider (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .step      (state_q == CALC),
    .dividend  (mag_a),
    .divisor   (mag_b),
    .quot_next (quot_next),
    .rem_next  (rem_next),
    .div_zero  (div_zero)
  );

  // Divide by zero yields all ones regardless of operand signs.
  assign quot_fix  = div_zero ? '1 : ((neg_a_q ^ neg_b_q) ? -quot_next : quot_next);
  assign rem_fix   = neg_a_q ? -rem_next : rem_next;
  assign illegal_d = 1'b0;
`else
  assign quot_fix  = '0;
  assign rem_fix   = '0;
  assign illegal_d = op[2];
`endif

  always_comb begin
    result_d = rem_fix;
    case (op_q)
      OP_MUL:                        result_d = prod_fix[W-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  result_d = prod_fix[2*W-1:W];
      OP_DIV, OP_DIVU:               result_d = quot_fix;
      default:                       result_d = rem_fix;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      op_q      <= OP_MUL;
      neg_a_q   <= 1'b0;
      neg_b_q   <= 1'b0;
      illegal_q <= 1'b0;
      mcand_q   <= '0;
      prod_q    <= '0;
      rd_q      <= '0;
      result_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        count_q   <= '0;
        op_q      <= op_in;
        neg_a_q   <= sign_a;
        neg_b_q   <= sign_b;
        illegal_q <= illegal_d;
        mcand_q   <= mag_a;
        prod_q    <= {{W{1'b0}}, mag_b};
        rd_q      <= rd_in;
      end else if (state_q == CALC) begin
        count_q <= count_q + CW'(1);
        prod_q  <= prod_next;
        if (last) result_q <= result_d;
      end
    end
  end

  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign result     = result_q;
  assign rd_out     = rd_q;
  assign illegal_op = done & illegal_q;
  assign wb_en      = done & (rd_q != '0) & ~illegal_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized scoreboard bench for muldiv_unit against a plain-arithmetic
// RV32M reference model; follows MULDIV_DIV_EN the same way as the design.
module tb_muldiv_unit;

  localparam int W  = 32;
  localparam int AW = 5;
  localparam int EW = W + AW + 2;
  localparam int LAT = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [2:0]    op;
  logic [W-1:0]  rs1_val, rs2_val;
  logic [AW-1:0] rd_in;
  logic          busy, done, wb_en, illegal_op;
  logic [W-1:0]  result;
  logic [AW-1:0] rd_out;

  muldiv_unit #(.DATA_WIDTH(W), .ADDRESS_WIDTH(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .op         (op),
    .rs1_val    (rs1_val),
    .rs2_val    (rs2_val),
    .rd_in      (rd_in),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .rd_out     (rd_out),
    .wb_en      (wb_en),
    .illegal_op (illegal_op)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard state
  logic [EW-1:0] exp_q[$];
  int unsigned   acc_q[$];
  int            checks = 0;
  int            fails  = 0;
  logic          prev_done = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model straight from the RV32M definitions.
  function automatic logic [EW-1:0] model(input logic [2:0] f, input logic [W-1:0] a,
                                          input logic [W-1:0] b, input logic [AW-1:0] rd);
    logic [W-1:0] r;
    logic         ill;
    longint       sp;
    logic [63:0]  up;
    logic         ovf;
    ill = 1'b0;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    r   = '0;
    case (f)
      3'd0: begin up = {32'b0, a} * {32'b0, b}; r = up[31:0]; end
      3'd1: begin sp = longint'($signed(a)) * longint'($signed(b)); r = sp[63:32]; end
      3'd2: begin sp = longint'($signed(a)) * longint'({32'b0, b}); r = sp[63:32]; end
      3'd3: begin up = {32'b0, a} * {32'b0, b}; r = up[63:32]; end
      3'd4: r = (b == 0) ? 32'hFFFF_FFFF : ovf ? a : $signed(a) / $signed(b);
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: r = (b == 0) ? a : ovf ? 32'h0 : $signed(a) % $signed(b);
      default: r = (b == 0) ? a : a % b;
    endcase
`ifndef MULDIV_DIV_EN
    if (f[2]) begin
      r   = '0;
      ill = 1'b1;
    end
`endif
    return {r, rd, (rd != 0) && !ill, ill};
  endfunction

  // Monitor: pops one expectation per done pulse.
  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        if (prev_done) begin
          checks++; fails++;
          $display("FAIL done_width: done high %0d cycles in a row, required 1", 2);
        end
        if (exp_q.size() == 0) begin
          checks++; fails++;
          $display("FAIL spurious_done: done=1 with no outstanding request, required done=0");
        end else begin
          logic [EW-1:0] e;
          int unsigned   t;
          e = exp_q.pop_front();
          t = acc_q.pop_front();
          check("result",     64'(result),     64'(e[EW-1 -: W]));
          check("rd_out",     64'(rd_out),     64'(e[AW+1:2]));
          check("wb_en",      64'(wb_en),      64'(e[1]));
          check("illegal_op", 64'(illegal_op), 64'(e[0]));
          check("latency",    64'(cyc - t),    64'(LAT));
        end
      end else if (wb_en || illegal_op) begin
        checks++; fails++;
        $display("FAIL strobe_without_done: wb_en=%0b illegal_op=%0b, required 0", wb_en, illegal_op);
      end
      prev_done <= done;
    end else begin
      prev_done <= 1'b0;
    end
  end

  // Driver tasks
  task automatic wait_idle();
    int t = 0;
    @(negedge clk);
    while (busy && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (busy) begin
      checks++; fails++;
      $display("FAIL idle_timeout: busy=1 after %0d cycles, required 0", t);
    end
  endtask

  task automatic issue(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [AW-1:0] rd, input bit track);
    wait_idle();
    start   = 1'b1;
    op      = f;
    rs1_val = a;
    rs2_val = b;
    rd_in   = rd;
    @(posedge clk);
    #1;
    check("accept_busy", 64'(busy), 64'd1);
    if (track) begin
      exp_q.push_back(model(f, a, b, rd));
      acc_q.push_back(cyc);
    end
    start   = 1'b0;
    op      = 3'($urandom_range(0, 7));
    rs1_val = $urandom;
    rs2_val = $urandom;
    rd_in   = AW'($urandom);
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      checks++; fails++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
      exp_q.delete();
      acc_q.delete();
    end
  endtask

  function automatic logic [W-1:0] pick_operand();
    logic [W-1:0] corners [4];
    corners[0] = 32'h0;
    corners[1] = 32'h1;
    corners[2] = 32'hFFFF_FFFF;
    corners[3] = 32'h8000_0000;
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 3)];
    return $urandom;
  endfunction

  initial begin
    rst = 1'b1; start = 1'b0; op = '0; rs1_val = '0; rs2_val = '0; rd_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",       64'(busy),       64'd0);
    check("rst_done",       64'(done),       64'd0);
    check("rst_wb_en",      64'(wb_en),      64'd0);
    check("rst_illegal_op", 64'(illegal_op), 64'd0);
    check("rst_result",     64'(result),     64'd0);
    check("rst_rd_out",     64'(rd_out),     64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases
    issue(3'd0, 32'd7,          32'hFFFF_FFFD, 5'd5, 1'b1);
    issue(3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd1, 1'b1);
    issue(3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd2, 1'b1);
    issue(3'd4, 32'hFFFF_FFEC,  32'd3,         5'd3, 1'b1);
    issue(3'd6, 32'hFFFF_FFEC,  32'd3,         5'd4, 1'b1);
    issue(3'd5, 32'd100,        32'd0,         5'd6, 1'b1);
    issue(3'd7, 32'd100,        32'd0,         5'd7, 1'b1);
    issue(3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd8, 1'b1);
    issue(3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd9, 1'b1);
    issue(3'd4, 32'hFFFF_FFEC,  32'd0,         5'd10, 1'b1);
    issue(3'd0, 32'd2,          32'd2,         5'd0, 1'b1);
    issue(3'd4, 32'd6,          32'd2,         5'd11, 1'b1);
    issue(3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd12, 1'b1);

    // Random traffic
    for (int i = 0; i < 40; i++)
      issue(3'($urandom_range(0, 7)), pick_operand(), pick_operand(), AW'($urandom), 1'b1);
    drain();

    // start held high: accepts only from IDLE, one every LAT+2 cycles
    begin
      int          n_acc = 0;
      int unsigned first_acc = 0, last_acc = 0;
      logic        was_busy = 1'b0;
      wait_idle();
      start = 1'b1; op = 3'd0; rs1_val = 32'd3; rs2_val = 32'hFFFF_FFFB; rd_in = 5'd17;
      for (int i = 0; i < 3 * (LAT + 2); i++) begin
        @(posedge clk);
        #1;
        if (busy && !was_busy) begin
          exp_q.push_back(model(3'd0, 32'd3, 32'hFFFF_FFFB, 5'd17));
          acc_q.push_back(cyc);
          if (n_acc == 0) first_acc = cyc;
          last_acc = cyc;
          n_acc++;
        end
        was_busy = busy;
      end
      start = 1'b0;
      check("held_start_accepts", 64'(n_acc), 64'd3);
      check("held_start_period",  64'(last_acc - first_acc), 64'(2 * (LAT + 2)));
      drain();
    end

    // Reset in the middle of a calculation
    issue(3'd0, 32'd9, 32'd9, 5'd13, 1'b0);
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy",   64'(busy),   64'd0);
    check("midrst_done",   64'(done),   64'd0);
    check("midrst_rd_out", 64'(rd_out), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (LAT + 4) @(negedge clk);
    issue(3'd0, 32'hFFFF_FFFE, 32'd21, 5'd14, 1'b1);
    issue(3'd5, 32'd1000, 32'd7, 5'd15, 1'b1);
    drain();

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
